mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 120 ++++++++++++
 tb/tb_mem_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory stage that issues loads/stores, waits for dmem_ack with
// a timeout, and emits one writeback record per instruction.
// Ports:
//   clk, reset_n (sync, active-low).
//   in_*: execute result and load/store/register-write controls.
//   in_ready, stall: upstream handshake.
//   dmem_*: data memory request/response.
//   wb_*: writeback record.
//   err: sticky error flag.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_reg_write,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_rt,
  input  logic [4:0]  in_dst_addr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_dst_addr,
  output logic [31:0] wb_data,
  output logic        stall,
  output logic        err
);

  localparam logic [7:0] TO = 8'(TIMEOUT_CYCLES);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic        lat_rw;
  logic [4:0]  lat_dst;

  logic is_mem;
  assign is_mem   = in_mem_read | in_mem_write;
  assign in_ready = (state == IDLE);
  assign stall    = in_valid & ~in_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_rw       <= 1'b0;
      lat_dst      <= '0;
      err          <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_dst_addr  <= '0;
      wb_data      <= '0;
    end else begin
      wb_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid && !is_mem) begin
            wb_valid     <= 1'b1;
            wb_data      <= in_alu;
            wb_reg_write <= in_reg_write;
            wb_dst_addr  <= in_dst_addr;
          end else if (in_valid) begin
            // Read+write together is treated as a store and flagged.
            state      <= ACCESS;
            cnt        <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= in_mem_write;
            dmem_addr  <= in_alu;
            dmem_wdata <= in_rt;
            lat_rw     <= in_reg_write;
            lat_dst    <= in_dst_addr;
            if (in_mem_read && in_mem_write)
              err <= 1'b1;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            state        <= IDLE;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            wb_valid     <= 1'b1;
            wb_dst_addr  <= lat_dst;
            wb_reg_write <= dmem_we ? 1'b0 : lat_rw;
            wb_data      <= dmem_we ? dmem_addr : dmem_rdata;
          end else if (cnt == TO) begin
            // Timeout: abort with an empty record and latch the error.
            state        <= IDLE;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            wb_valid     <= 1'b1;
            wb_dst_addr  <= lat_dst;
            wb_reg_write <= 1'b0;
            wb_data      <= '0;
            err          <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of mem_stage with TIMEOUT_CYCLES=4.
// Inputs change #1 after posedge; outputs are checked at that point too.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic        in_mem_read, in_mem_write, in_reg_write;
  logic [31:0] in_alu, in_rt;
  logic [4:0]  in_dst_addr;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_dst_addr;
  logic [31:0] wb_data;
  logic        stall, err;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_reg_write(in_reg_write),
    .in_alu(in_alu), .in_rt(in_rt), .in_dst_addr(in_dst_addr),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_dst_addr(wb_dst_addr), .wb_data(wb_data),
    .stall(stall), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr,
                       input logic rw, input logic [31:0] alu,
                       input logic [31:0] rt, input logic [4:0] dst);
    in_valid     = v;
    in_mem_read  = rd;
    in_mem_write = wr;
    in_reg_write = rw;
    in_alu       = alu;
    in_rt        = rt;
    in_dst_addr  = dst;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    idle_in();
    tick();
    tick();
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 1);
    reset_n = 1'b1;
    tick();

    // ALU op
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h2A, 32'h0, 5'd5);
    chk("alu_stall", stall, 0);
    tick();
    idle_in();
    chk("alu_wb_valid", wb_valid, 1);
    chk("alu_wb_data", wb_data, 32'h2A);
    chk("alu_wb_dst", wb_dst_addr, 5);
    chk("alu_wb_rw", wb_reg_write, 1);
    tick();
    chk("alu_pulse", wb_valid, 0);
    chk("alu_hold", wb_data, 32'h2A);

    // Load with 3 wait cycles; upstream keeps in_valid high
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 5'd7);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("ld_req", dmem_req, 1);
      chk("ld_we", dmem_we, 0);
      chk("ld_addr", dmem_addr, 32'h10);
      chk("ld_stall", stall, 1);
      chk("ld_no_wb", wb_valid, 0);
      if (i == 3) begin
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
      end
      tick();
    end
    dmem_ack = 1'b0;
    idle_in();
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_wb_data", wb_data, 32'hDEADBEEF);
    chk("ld_wb_rw", wb_reg_write, 1);
    chk("ld_wb_dst", wb_dst_addr, 7);
    chk("ld_req_off", dmem_req, 0);
    chk("ld_ready", in_ready, 1);
    tick();

    // Store, ack on first ACCESS cycle
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 32'h1234, 5'd9);
    tick();
    idle_in();
    dmem_ack = 1'b1;
    chk("st_req", dmem_req, 1);
    chk("st_we", dmem_we, 1);
    chk("st_wdata", dmem_wdata, 32'h1234);
    chk("st_ready_lo", in_ready, 0);
    tick();
    dmem_ack = 1'b0;
    chk("st_wb_valid", wb_valid, 1);
    chk("st_wb_rw", wb_reg_write, 0);
    chk("st_wb_data", wb_data, 32'h20);
    chk("st_ready", in_ready, 1);
    chk("st_we_off", dmem_we, 0);
    chk("st_err", err, 0);

    // Ack exactly when counter reaches timeout: normal completion
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h30, 32'h0, 5'd2);
    tick();
    idle_in();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFE0001;
      end
      tick();
    end
    dmem_ack = 1'b0;
    chk("edge_wb_valid", wb_valid, 1);
    chk("edge_wb_data", wb_data, 32'hCAFE0001);
    chk("edge_err", err, 0);

    // Timeout: abort after 5 ACCESS cycles
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 5'd4);
    tick();
    idle_in();
    for (int i = 0; i < 5; i++) begin
      chk("to_req", dmem_req, 1);
      chk("to_no_wb", wb_valid, 0);
      tick();
    end
    chk("to_wb_valid", wb_valid, 1);
    chk("to_wb_data", wb_data, 0);
    chk("to_wb_rw", wb_reg_write, 0);
    chk("to_err", err, 1);
    chk("to_req_off", dmem_req, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h55, 32'h0, 5'd1);
    tick();
    idle_in();
    chk("sticky_wb", wb_data, 32'h55);
    chk("sticky_err", err, 1);

    // Reset mid-load, later ack ignored
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h50, 32'h0, 5'd6);
    tick();
    idle_in();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mr_req", dmem_req, 0);
    chk("mr_addr", dmem_addr, 0);
    chk("mr_wb_valid", wb_valid, 0);
    chk("mr_wb_data", wb_data, 0);
    chk("mr_wb_dst", wb_dst_addr, 0);
    chk("mr_err", err, 0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h11111111;
    tick();
    dmem_ack = 1'b0;
    chk("mr_ack_ign", wb_valid, 0);
    chk("mr_ready", in_ready, 1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h99, 32'h0, 5'd3);
    tick();
    idle_in();
    chk("mr_alu_v", wb_valid, 1);
    chk("mr_alu_d", wb_data, 32'h99);

    // Read and write both set: store with error
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h60, 32'h77, 5'd8);
    tick();
    idle_in();
    dmem_ack = 1'b1;
    chk("both_we", dmem_we, 1);
    chk("both_wdata", dmem_wdata, 32'h77);
    chk("both_err", err, 1);
    tick();
    dmem_ack = 1'b0;
    chk("both_wb_rw", wb_reg_write, 0);
    chk("both_wb_data", wb_data, 32'h60);
    tick();

    // Eight back-to-back ALU ops
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h100 + 32'(i), 32'h0, 5'(i));
      chk("b2b_stall", stall, 0);
      tick();
      chk("b2b_valid", wb_valid, 1);
      chk("b2b_data", wb_data, 32'h100 + 32'(i));
      chk("b2b_dst", wb_dst_addr, 32'(i));
    end
    idle_in();
    tick();
    chk("b2b_end", wb_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
